// File: rtl/logic_op_issuer.sv
// Command issuer for the 8-bit logic unit: 2-entry command FIFO, issue FSM, result handshake.
// Optional golden-model self-check built when LOGIC_OP_ISSUER_SELFCHECK_EN is defined.
module logic_op_issuer #(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   output logic [7:0] lu_a,
   output logic [7:0] lu_b,
   output logic [1:0] lu_sel,
   input  logic [7:0] lu_f,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic [1:0] res_op,
   output logic       res_err,
   output logic       err_sticky,
   output logic [7:0] op_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   localparam logic [1:0] FULL = 2'(DEPTH);

   state_t     state;
   logic [1:0] fifo_op [DEPTH];
   logic [7:0] fifo_a  [DEPTH];
   logic [7:0] fifo_b  [DEPTH];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count;
   logic [1:0] count_nxt;
   logic       push;
   logic       pop;
   logic [1:0] head_op;
   logic [7:0] head_a;
   logic [7:0] head_b;

   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == ISSUE);
   assign count_nxt = count + {1'b0, push} - {1'b0, pop};
   assign head_op   = fifo_op[rd_ptr];
   assign head_a    = fifo_a[rd_ptr];
   assign head_b    = fifo_b[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_op[i] <= 2'b00;
            fifo_a[i]  <= 8'h00;
            fifo_b[i]  <= 8'h00;
         end
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
         cmd_ready <= 1'b0;
         state     <= IDLE;
         lu_a      <= 8'h00;
         lu_b      <= 8'h00;
         lu_sel    <= 2'b00;
         res_valid <= 1'b0;
         res_data  <= 8'h00;
         res_op    <= 2'b00;
         op_count  <= 8'h00;
      end else begin
         if (push) begin
            fifo_op[wr_ptr] <= cmd_op;
            fifo_a[wr_ptr]  <= cmd_a;
            fifo_b[wr_ptr]  <= cmd_b;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count     <= count_nxt;
         // Registered from the post-edge count: no path from the handshakes.
         cmd_ready <= (count_nxt != FULL);
         case (state)
            IDLE: begin
               if (count != 2'd0) begin
                  state  <= ISSUE;
                  lu_a   <= head_a;
                  lu_b   <= head_b;
                  lu_sel <= head_op;
               end
            end
            ISSUE: begin
               state     <= RESP;
               res_data  <= lu_f;
               res_op    <= head_op;
               res_valid <= 1'b1;
            end
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  op_count  <= op_count + 8'd1;
                  if (count != 2'd0) begin
                     state  <= ISSUE;
                     lu_a   <= head_a;
                     lu_b   <= head_b;
                     lu_sel <= head_op;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef LOGIC_OP_ISSUER_SELFCHECK_EN
   logic [7:0] expect_f;

   always_comb begin
      expect_f = 8'h00;
      unique case (1'b1)
         (head_op == 2'b00): expect_f = head_a & head_b;
         (head_op == 2'b01): expect_f = head_a | head_b;
         (head_op == 2'b10): expect_f = head_a ^ head_b;
         (head_op == 2'b11): expect_f = ~head_a;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_err    <= 1'b0;
         err_sticky <= 1'b0;
      end else if (state == ISSUE) begin
         res_err <= (lu_f != expect_f);
         if (lu_f != expect_f) err_sticky <= 1'b1;
      end
   end
`else
   assign res_err    = 1'b0;
   assign err_sticky = 1'b0;
`endif

endmodule
